// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [3:0] value;
        logic       dot;
        logic       on;
    } digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex value plus decimal point to active-low segments (bit7=a ... bit1=g, bit0=dp).
module seg7_decode (
    input  logic [3:0] value,
    input  logic       dot,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (value)
            4'h0: seg = 8'h03;
            4'h1: seg = 8'h9F;
            4'h2: seg = 8'h25;
            4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h49;
            4'h6: seg = 8'h41;
            4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01;
            4'h9: seg = 8'h09;
            4'hA: seg = 8'h11;
            4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63;
            4'hD: seg = 8'h85;
            4'hE: seg = 8'h61;
            4'hF: seg = 8'h71;
            default: seg = 8'hFF;
        endcase
        seg[0] = ~dot;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit scan controller with double-buffered digit banks and anti-ghost gaps.
// Optional leading-zero blanking (lz_blank port) is built when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 16
) (
`ifdef SEG_LZ_BLANK_EN
    input  logic       lz_blank,
`endif
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dot,
    input  logic       wr_on,
    input  logic       commit,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_start
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_gap;

    digit_t           shadow [NUM_DIGITS];
    digit_t           active [NUM_DIGITS];
    logic             pending_q;
    logic             wr_fire, commit_take, copy;

    digit_t           cur;
    logic [7:0]       dec_seg;
    logic             lz_hide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_W'(1);
        last_gap = 1'b0;
        case (state_q)
            SHOW: if (cnt_q == SHOW_LAST) begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (cnt_q == GAP_LAST) begin
                state_d  = SHOW;
                cnt_d    = '0;
                idx_d    = idx_q + 3'd1;
                last_gap = (idx_q == 3'd7);
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset also drops wr_ready so no write can land while banks are being cleared.
    assign wr_ready    = rst_n & ~pending_q;
    assign wr_fire     = wr_valid & wr_ready;
    assign commit_take = commit & ~pending_q;
    assign copy        = last_gap & pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (copy)
                pending_q <= 1'b0;
            else if (commit_take)
                pending_q <= 1'b1;
            if (wr_fire)
                shadow[wr_addr] <= '{value: wr_data, dot: wr_dot, on: wr_on};
            if (copy)
                for (int i = 0; i < NUM_DIGITS; i++)
                    active[i] <= shadow[i];
        end
    end

    assign cur = active[idx_q];

    seg7_decode u_decode (
        .value (cur.value),
        .dot   (cur.dot),
        .seg   (dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    // Hidden only if this digit and every enabled digit above it is a plain zero.
    always_comb begin
        lz_hide = lz_blank && (idx_q != 3'd0);
        for (int j = 0; j < NUM_DIGITS; j++)
            if (j >= int'(idx_q) && active[j].on && (active[j].value != 4'h0 || active[j].dot))
                lz_hide = 1'b0;
    end
`else
    assign lz_hide = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= SEG_BLANK;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            an          <= (state_q == SHOW) ? ~(8'd1 << idx_q) : SEG_BLANK;
            seg         <= (state_q == SHOW && cur.on && !lz_hide) ? dec_seg : SEG_BLANK;
            frame_start <= (state_q == SHOW) && (idx_q == 3'd0) && (cnt_q == '0);
        end
    end

endmodule
